// File: rtl/ni_pkg.sv
// Shared definitions for the GPU network interface: address mapping helpers,
// mapping result type and default flit layout.
package ni_pkg;

  // Routing header = GPU ID + ADDR_OFFSET.
  localparam int unsigned ADDR_OFFSET = 3;

  // Working width of the mapping helpers; ID_W of any instance must not exceed it.
  localparam int unsigned MaxIdW = 16;

  // Default flit layout: {id/header, payload}.
  localparam int unsigned DefDataW  = 16;
  localparam int unsigned DefIdW    = 6;
  localparam int unsigned DefIdLsb  = DefDataW - DefIdW;
  localparam int unsigned DefPayW   = DefIdLsb;

  typedef logic [MaxIdW-1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  hdr;
  } hdr_map_t;

  // Forward mapping; only IDs 1..num_gpus produce a valid header.
  function automatic hdr_map_t id_to_hdr(id_t id, int unsigned num_gpus);
    hdr_map_t m;
    m.valid = (id != '0) && (32'(id) <= num_gpus);
    m.hdr   = id + id_t'(ADDR_OFFSET);
    return m;
  endfunction

  // Reverse mapping from routing header back to GPU ID.
  function automatic id_t hdr_to_id(id_t hdr);
    return hdr - id_t'(ADDR_OFFSET);
  endfunction

endpackage

// File: rtl/ni_fifo_oreg.sv
// Synchronous FIFO followed by a registered valid/ready output stage.
// Level counts FIFO entries only; the output register adds one more slot.
module ni_fifo_oreg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic                     full_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop, empty;

  // Full/empty come only from the registered count so ready never depends on a
  // same-cycle pop.
  assign full_o = (count_q == LvlW'(DEPTH));
  assign empty  = (count_q == '0);
  assign push   = push_i && !full_o;
  assign pop    = !empty && (!out_valid_q || out_ready_i);

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign level_o     = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Output stage: refill from the head whenever empty or being consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage array; contents need no reset since pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // The parent only pushes when ready (= !full) was high.
  push_not_full_a : assert property (@(posedge clk_i) disable iff (rst_i) push_i |-> !full_o);

  // Valid and data hold while stalled.
  out_hold_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)));

endmodule

// File: rtl/ni_v2.sv
// GPU network interface: maps GPU destination IDs to routing headers on TX,
// filters and restores IDs on RX, and counts discarded flits.
module ni_v2
  import ni_pkg::*;
#(
  parameter int unsigned GPU_ID     = 25,
  parameter int unsigned NUM_GPUS   = 32,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ID_W       = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             gpu_data_in,
  input  logic                          gpu_valid_in,
  output logic                          gpu_ready_out,
  output logic [DATA_W-1:0]             gpu_data_out,
  output logic                          gpu_valid_out,
  input  logic                          gpu_ready_in,
  output logic [DATA_W-1:0]             router_data_out,
  output logic                          router_valid_out,
  input  logic                          router_ready_in,
  input  logic [DATA_W-1:0]             router_data_in,
  input  logic                          router_valid_in,
  output logic                          router_ready_out,
  output logic [CNT_W-1:0]              tx_drop_cnt,
  output logic [CNT_W-1:0]              rx_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int unsigned IdLsb = DATA_W - ID_W;
  localparam id_t         OwnHdr = id_t'(GPU_ID + ADDR_OFFSET);

  // ---------------------------------------------------------------- TX path
  logic [ID_W-1:0]   tx_dest;
  logic [IdLsb-1:0]  tx_payload;
  hdr_map_t          tx_map;
  logic [DATA_W-1:0] tx_flit;
  logic              tx_full, tx_accept, tx_push, tx_drop_inc;

  assign tx_dest     = gpu_data_in[DATA_W-1:IdLsb];
  assign tx_payload  = gpu_data_in[IdLsb-1:0];
  assign tx_map      = id_to_hdr(id_t'(tx_dest), NUM_GPUS);
  assign tx_flit     = {tx_map.hdr[ID_W-1:0], tx_payload};
  assign gpu_ready_out = !tx_full;
  assign tx_accept   = gpu_valid_in && gpu_ready_out;
  // Invalid destinations are still accepted so the GPU never stalls on them.
  assign tx_push     = tx_accept && tx_map.valid;
  assign tx_drop_inc = tx_accept && !tx_map.valid;

  ni_fifo_oreg #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (tx_push),
    .push_data_i (tx_flit),
    .full_o      (tx_full),
    .out_data_o  (router_data_out),
    .out_valid_o (router_valid_out),
    .out_ready_i (router_ready_in),
    .level_o     (tx_level)
  );

  // ---------------------------------------------------------------- RX path
  logic [ID_W-1:0]   rx_hdr;
  logic [IdLsb-1:0]  rx_payload;
  id_t               rx_id;
  logic [DATA_W-1:0] rx_flit;
  logic              rx_full, rx_accept, rx_match, rx_push, rx_drop_inc;

  assign rx_hdr      = router_data_in[DATA_W-1:IdLsb];
  assign rx_payload  = router_data_in[IdLsb-1:0];
  assign rx_match    = (id_t'(rx_hdr) == OwnHdr);
  assign rx_id       = hdr_to_id(id_t'(rx_hdr));
  assign rx_flit     = {rx_id[ID_W-1:0], rx_payload};
  assign router_ready_out = !rx_full;
  assign rx_accept   = router_valid_in && router_ready_out;
  assign rx_push     = rx_accept && rx_match;
  assign rx_drop_inc = rx_accept && !rx_match;

  ni_fifo_oreg #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (rx_push),
    .push_data_i (rx_flit),
    .full_o      (rx_full),
    .out_data_o  (gpu_data_out),
    .out_valid_o (gpu_valid_out),
    .out_ready_i (gpu_ready_in),
    .level_o     (rx_level)
  );

  // Upper mapping bits beyond ID_W are intentionally discarded.
  logic unused_map_bits;
  assign unused_map_bits = ^{tx_map.hdr, rx_id};

  // ---------------------------------------------------------------- Drop counters
  logic [CNT_W-1:0] tx_drop_q, tx_drop_d;
  logic [CNT_W-1:0] rx_drop_q, rx_drop_d;

  // Saturating increments; counters stick at all-ones.
  always_comb begin
    tx_drop_d = tx_drop_q;
    rx_drop_d = rx_drop_q;
    if (tx_drop_inc && (tx_drop_q != '1)) tx_drop_d = tx_drop_q + 1'b1;
    if (rx_drop_inc && (rx_drop_q != '1)) rx_drop_d = rx_drop_q + 1'b1;
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop_q <= '0;
      rx_drop_q <= '0;
    end else begin
      tx_drop_q <= tx_drop_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  assign tx_drop_cnt = tx_drop_q;
  assign rx_drop_cnt = rx_drop_q;

endmodule

// File: doc/ni_v2.md
Name: ni_v2

Overview:
- Parametrised second-generation GPU network interface between one GPU port and its leaf router port.
- TX path: converts the GPU destination ID in the flit's upper ID_W bits into a routing header, buffers the flit, and presents it to the router with a held valid/ready handshake.
- RX path: accepts router flits with backpressure, keeps only flits whose header matches this GPU, restores the GPU ID, and buffers them toward the GPU.
- Adds saturating drop counters and FIFO level outputs.

Parameters:
- GPU_ID, 25, ID of the attached GPU (1..NUM_GPUS).
- NUM_GPUS, 32, highest valid GPU ID.
- DATA_W, 16, flit width; payload = DATA_W-ID_W bits.
- ID_W, 6, GPU ID / routing header width (4-bit group + 2-bit leaf).
- FIFO_DEPTH, 8, entries per FIFO; power of two, >=2.
- CNT_W, 8, drop counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- gpu_data_in  in  DATA_W  {dest_id, payload} from GPU.
- gpu_valid_in  in  1  GPU flit valid.
- gpu_ready_out  out  1  NI can accept a GPU flit.
- gpu_data_out  out  DATA_W  {GPU_ID, payload} to GPU.
- gpu_valid_out  out  1  flit to GPU valid.
- gpu_ready_in  in  1  GPU accepts flit.
- router_data_out  out  DATA_W  {header, payload} to router.
- router_valid_out  out  1  flit to router valid.
- router_ready_in  in  1  router accepts flit.
- router_data_in  in  DATA_W  {header, payload} from router.
- router_valid_in  in  1  router flit valid.
- router_ready_out  out  1  NI can accept a router flit.
- tx_drop_cnt  out  CNT_W  GPU flits with invalid destination.
- rx_drop_cnt  out  CNT_W  router flits not addressed to GPU_ID.
- tx_level  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy (output register not counted).
- rx_level  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy (output register not counted).

Behaviour:
- Mapping:
  - header = dest_id + 3 for dest_id in 1..NUM_GPUS; any other value is invalid.
  - Reverse mapping: id = header - 3.
  - Example: own header for GPU_ID 25 is 6'b011100.
- Handshake rules:
  - A transfer occurs on a rising edge where valid && ready.
  - Once raised, valid and data are held unchanged until the transfer completes.
- gpu_ready_out = !tx_full, and router_ready_out = !rx_full.
  - Both are driven only from registered count, never from a same-cycle pop.
  - A push to a full FIFO is therefore impossible, even with a simultaneous pop.
- TX accept:
  - A valid destination writes {header, payload} into the TX FIFO.
  - An invalid destination is accepted and discarded; tx_drop_cnt increments.
- RX accept:
  - A header equal to the own header writes {GPU_ID, payload} into the RX FIFO.
  - Any other header is accepted and discarded; rx_drop_cnt increments.
- Output stage, per path:
  - The output register loads the FIFO head when the FIFO is non-empty and (output is not valid, or it is consumed this cycle).
  - Valid clears when consumed with the FIFO empty.
  - Back-to-back consumption sustains 1 flit per cycle.
- Latency: a flit accepted at edge N is visible on the output after edge N+1.
- Ordering: strict FIFO order per path; pointers wrap modulo FIFO_DEPTH.
- Capacity per path: FIFO_DEPTH + 1 flits (FIFO plus output register).
- Simultaneous push and pop: level is unchanged, both operations occur.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset, including mid-transfer:
  - Pointers, levels and counters go to 0; all valid outputs go to 0; data outputs go to 0.
  - In-flight flits are lost.
  - Ready outputs are 1 in the cycle after reset deasserts.
- TX and RX paths are fully independent.

Decomposition:
- Package ni_pkg:
  - ADDR_OFFSET = 3.
  - Functions id_to_hdr(id) returning {valid, header} and hdr_to_id(header).
  - Flit field slice constants.
- Sub-module ni_fifo_oreg: synchronous FIFO with registered valid/ready output stage, level output and parameters WIDTH/DEPTH.
  - Instantiated twice: TX and RX.
- Top level holds only mapping, filtering and counters.

Test Plan:
- TX basic: gpu_data_in=16'h0555 with dest_id field 1 (i.e. 16'h0555), router_ready_in=1 -> router_data_out=16'h1155 one cycle after acceptance; tx_drop_cnt=0.
- RX basic: router_data_in=16'h72AA -> gpu_data_out=16'h66AA; rx_drop_cnt=0. Misrouted router_data_in=16'h1155 -> no gpu_valid_out; rx_drop_cnt=1; router_ready_out stays 1.
- Invalid destinations:
  - dest_id 0, 33 and 63 each accepted, no router output, tx_drop_cnt=3.
  - With CNT_W=2, 5 invalid flits -> tx_drop_cnt holds at 3.
- Backpressure/full:
  - router_ready_in=0, stream 10 valid flits -> 9 accepted, gpu_ready_out=0 after the 9th, tx_level=8.
  - Release router_ready_in -> 9 flits emerge in order on consecutive cycles; router_valid_out is held stable while stalled.
- Wrap and concurrency: continuous streams of 40 flits with random ready on both paths -> no loss, no duplication, order preserved; level is unchanged on cycles with simultaneous push and pop.
- Reset mid-operation: assert reset with 5 flits buffered and valid_out high -> next cycle all valids 0, levels 0, counters 0; a new flit afterwards passes normally.
